// File: rtl/mesh_run_pkg.sv
// Shared types for the mesh run controller.
// Default widths match the controller's default parameters.
package mesh_run_pkg;

  localparam int DEF_NODES  = 16;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NW     = $clog2(DEF_NODES);

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    RUN,
    DUMP,
    DONE
  } run_state_t;

  typedef struct packed {
    logic [DEF_NW-1:0]     node;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
    logic                  last;
  } dump_word_t;

endpackage

// File: rtl/dump_skid_fifo.sv
// Two-entry valid/ready buffer for dumped words.
// Occupancy is exported for the controller's read-credit check.
module dump_skid_fifo
  import mesh_run_pkg::*;
#(
  parameter type T = dump_word_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_valid,
  input  T           push_word,
  output logic       pop_valid,
  input  logic       pop_ready,
  output T           pop_word,
  output logic [1:0] count
);

  T           mem_q [2];
  logic       wr_q;
  logic       rd_q;
  logic [1:0] cnt_q;
  logic       push;
  logic       pop;

  assign pop_valid = (cnt_q != 2'd0);
  assign pop       = pop_valid && pop_ready;
  assign push      = push_valid && ((cnt_q != 2'd2) || pop);
  assign pop_word  = mem_q[rd_q];
  assign count     = cnt_q;

  // Ring storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_word;
        wr_q        <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/mesh_run_controller.sv
// Mesh run control: hold reset, run under a budget,
// then freeze the cores and stream out every node RAM.
module mesh_run_controller
  import mesh_run_pkg::*;
#(
  parameter int NODES         = DEF_NODES,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int CYC_W         = 32,
  parameter int HOLD_CYCLES   = 12,
  parameter int PROGRESS_STEP = 10000,
  localparam int NW = (NODES > 1) ? $clog2(NODES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CYC_W-1:0]  cycle_budget,
  input  logic [NODES-1:0]  node_done,
  output logic              core_rst_n,
  output logic              running,
  output logic              progress_tick,
  output logic              ram_rd_en,
  output logic [NW-1:0]     ram_rd_node,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [NW-1:0]     dump_node,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              timed_out,
  output logic              finished
);

  typedef struct packed {
    logic [NW-1:0]     node;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } word_t;

  localparam logic [CYC_W-1:0]  ONE      = CYC_W'(1);
  localparam logic [CYC_W-1:0]  STEP_M1  = CYC_W'(PROGRESS_STEP - 1);
  localparam logic [31:0]       HOLD_M1  = 32'(HOLD_CYCLES - 1);
  localparam logic [NW-1:0]     NODE_MAX = NW'(NODES - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  run_state_t        state_q;
  run_state_t        state_d;
  logic [CYC_W-1:0]  budget_q;
  logic [CYC_W-1:0]  cnt_q;
  logic [CYC_W-1:0]  pcnt_q;
  logic [31:0]       hcnt_q;
  logic              tick_q;
  logic              timed_out_q;

  logic [NW-1:0]     rd_node_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_done_q;
  logic              infl_q;
  logic [NW-1:0]     infl_node_q;
  logic [ADDR_W-1:0] infl_addr_q;
  logic              infl_last_q;

  logic              all_done;
  logic              expire;
  logic              accept;
  logic              rd_en;
  logic              rd_last;
  logic              pop;
  logic [2:0]        occ;
  logic [1:0]        fifo_cnt;
  logic              out_valid;
  word_t             in_word;
  word_t             out_word;

  assign all_done = &node_done;
  assign expire   = (budget_q != '0) && (cnt_q == budget_q - ONE);
  assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
  assign rd_last  = (rd_node_q == NODE_MAX) && (rd_addr_q == ADDR_MAX);
  assign pop      = out_valid && dump_ready;

  // A word leaving this cycle frees its slot for a read issued now.
  assign occ   = {1'b0, fifo_cnt} - {2'b0, pop} + {2'b0, infl_q};
  assign rd_en = (state_q == DUMP) && !rd_done_q && (occ < 3'd2);

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = HOLD;
      HOLD: if (hcnt_q == HOLD_M1) state_d = RUN;
      RUN: if (all_done || expire) state_d = DUMP;
      DUMP: if (pop && out_word.last) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // State, hold/run/progress counters and run-outcome flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      budget_q    <= '0;
      cnt_q       <= '0;
      pcnt_q      <= '0;
      hcnt_q      <= '0;
      tick_q      <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        budget_q    <= cycle_budget;
        timed_out_q <= 1'b0;
      end
      if (state_q == HOLD) hcnt_q <= hcnt_q + 32'd1;
      else hcnt_q <= '0;
      if (state_q == RUN) begin
        cnt_q  <= (&cnt_q) ? cnt_q : cnt_q + ONE;
        pcnt_q <= (pcnt_q == STEP_M1) ? '0 : pcnt_q + ONE;
      end else begin
        cnt_q  <= '0;
        pcnt_q <= '0;
      end
      tick_q <= (state_q == RUN) && (pcnt_q == STEP_M1);
      if ((state_q == RUN) && expire && !all_done) timed_out_q <= 1'b1;
    end
  end

  // Dump address walk and the single in-flight read tag.
  always_ff @(posedge clk) begin
    if (rst || (state_q != DUMP)) begin
      rd_node_q   <= '0;
      rd_addr_q   <= '0;
      rd_done_q   <= 1'b0;
      infl_q      <= 1'b0;
      infl_node_q <= '0;
      infl_addr_q <= '0;
      infl_last_q <= 1'b0;
    end else begin
      infl_q <= rd_en;
      if (rd_en) begin
        infl_node_q <= rd_node_q;
        infl_addr_q <= rd_addr_q;
        infl_last_q <= rd_last;
        if (rd_last) begin
          rd_done_q <= 1'b1;
        end else if (rd_addr_q == ADDR_MAX) begin
          rd_addr_q <= '0;
          rd_node_q <= rd_node_q + NW'(1);
        end else begin
          rd_addr_q <= rd_addr_q + ADDR_W'(1);
        end
      end
    end
  end

  assign in_word.node = infl_node_q;
  assign in_word.addr = infl_addr_q;
  assign in_word.data = ram_rd_data;
  assign in_word.last = infl_last_q;

  dump_skid_fifo #(
    .T (word_t)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (infl_q),
    .push_word  (in_word),
    .pop_valid  (out_valid),
    .pop_ready  (dump_ready),
    .pop_word   (out_word),
    .count      (fifo_cnt)
  );

  assign core_rst_n    = (state_q == RUN);
  assign running       = (state_q == RUN);
  assign progress_tick = tick_q;
  assign ram_rd_en     = rd_en;
  assign ram_rd_node   = rd_node_q;
  assign ram_rd_addr   = rd_addr_q;
  assign dump_valid    = out_valid;
  assign dump_node     = out_word.node;
  assign dump_addr     = out_word.addr;
  assign dump_data     = out_word.data;
  assign dump_last     = out_valid && out_word.last;
  assign timed_out     = timed_out_q;
  assign finished      = (state_q == DONE);

endmodule

// File: tb/tb_mesh_run_controller.sv
// Randomised scoreboard bench for mesh_run_controller
// on a 4-node, 4-word-per-node configuration.
module tb_mesh_run_controller;

  localparam int NODES = 4;
  localparam int ADDR_W = 2;
  localparam int DATA_W = 32;
  localparam int CYC_W = 32;
  localparam int HOLD = 12;
  localparam int STEP = 25;

  typedef struct packed {
    logic [1:0]  node;
    logic [1:0]  addr;
    logic [31:0] data;
    logic        last;
  } wexp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] cycle_budget;
  logic [3:0]  node_done;
  logic        core_rst_n;
  logic        running;
  logic        progress_tick;
  logic        ram_rd_en;
  logic [1:0]  ram_rd_node;
  logic [1:0]  ram_rd_addr;
  logic [31:0] ram_rd_data;
  logic        dump_valid;
  logic        dump_ready;
  logic [1:0]  dump_node;
  logic [1:0]  dump_addr;
  logic [31:0] dump_data;
  logic        dump_last;
  logic        timed_out;
  logic        finished;

  int          checks = 0;
  int          errors = 0;
  int          ticks = 0;
  int          pops = 0;
  int          ready_pct = 100;
  wexp_t       exp_q[$];
  logic [31:0] ram [4][4];

  mesh_run_controller #(
    .NODES(NODES), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .CYC_W(CYC_W), .HOLD_CYCLES(HOLD), .PROGRESS_STEP(STEP)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cycle_budget(cycle_budget), .node_done(node_done),
    .core_rst_n(core_rst_n), .running(running),
    .progress_tick(progress_tick), .ram_rd_en(ram_rd_en),
    .ram_rd_node(ram_rd_node), .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_node(dump_node),
    .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_last(dump_last), .timed_out(timed_out),
    .finished(finished)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM behaviour: data one cycle after the strobe, junk otherwise.
  always @(posedge clk)
    ram_rd_data <= ram_rd_en ? ram[ram_rd_node][ram_rd_addr] : $urandom;

  initial begin
    dump_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      dump_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] rst_vec();
    return 64'({core_rst_n, running, progress_tick, ram_rd_en,
                dump_valid, dump_last, timed_out, finished,
                dump_node, dump_addr, dump_data});
  endfunction

  // Monitor: scoreboard pops, stall stability, tick counting.
  initial begin
    logic        stalled;
    logic [36:0] held;
    logic [36:0] cur;
    wexp_t       e;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      cur = {dump_node, dump_addr, dump_data, dump_last};
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (progress_tick) ticks++;
        if (stalled)
          chk("stall_hold", 64'({dump_valid, cur}), 64'({1'b1, held}));
        if (dump_valid && dump_ready) begin
          pops++;
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 64'(cur), 64'(0));
          end else begin
            e = exp_q.pop_front();
            chk("dump_word", 64'(cur), 64'(e));
          end
        end
        stalled = dump_valid && !dump_ready;
        held = cur;
      end
    end
  end

  task automatic load(input bit seq);
    for (int n = 0; n < 4; n++)
      for (int a = 0; a < 4; a++) begin
        ram[n][a] = seq ? 32'(n * 4 + a) : $urandom;
        exp_q.push_back('{node: 2'(n), addr: 2'(a),
                          data: ram[n][a], last: (n == 3 && a == 3)});
      end
  endtask

  task automatic run_one(input int bud, input int done_at,
                         input int pct, input bit seq, input bit poke);
    int n;
    int len;
    bit to;
    len = (done_at >= 0) ? done_at + 1 : bud;
    to = 1'b0;
    if (bud != 0 && (done_at < 0 || bud < done_at + 1)) begin
      len = bud;
      to = 1'b1;
    end
    ready_pct = pct;
    load(seq);
    @(posedge clk);
    #1;
    cycle_budget = 32'(bud);
    start = 1'b1;
    ticks = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!core_rst_n && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("hold_len", 64'(n), 64'(HOLD));
    n = 0;
    while (running && n < 1000) begin
      node_done = (done_at >= 0 && n >= done_at) ? 4'hF : 4'h0;
      start = poke && (n == 5);
      if (poke) cycle_budget = 32'd7;
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    chk("run_len", 64'(n), 64'(len));
    chk("timed_out", 64'(timed_out), 64'(to));
    n = 0;
    while (!finished && n < 2000) begin
      if (n == 0) chk("frozen", 64'(core_rst_n), 64'(0));
      start = poke && (n == 3);
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    node_done = 4'h0;
    chk("finished", 64'(finished), 64'(1));
    chk("words_left", 64'(exp_q.size()), 64'(0));
    chk("ticks", 64'(ticks), 64'(len / STEP));
    chk("timed_out_kept", 64'(timed_out), 64'(to));
  endtask

  task automatic reset_mid_dump();
    int n;
    ready_pct = 50;
    load(1'b0);
    @(posedge clk);
    #1;
    cycle_budget = 32'd0;
    node_done = 4'hF;
    start = 1'b1;
    pops = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (pops < 5 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_dump", 64'(pops >= 5), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_reset", rst_vec(), 64'(0));
    rst = 1'b0;
    node_done = 4'h0;
    exp_q.delete();
  endtask

  initial begin
    int bud;
    int da;
    rst = 1'b1;
    start = 1'b0;
    cycle_budget = '0;
    node_done = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", rst_vec(), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_rst_n", 64'(core_rst_n), 64'(0));

    run_one(0, 49, 100, 1'b0, 1'b0);
    run_one(100, -1, 100, 1'b0, 1'b0);
    run_one(60, 59, 100, 1'b0, 1'b0);
    run_one(0, 30, 30, 1'b1, 1'b0);
    run_one(0, 40, 60, 1'b0, 1'b1);
    reset_mid_dump();
    run_one(20, -1, 70, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bud = $urandom_range(0, 120);
      da = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, 120);
      if (bud == 0 && da < 0) da = 10;
      run_one(bud, da, $urandom_range(20, 100), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mesh_run_controller.md
# mesh_run_controller

Run-control and memory-dump sequencer for the dual-CPU XY mesh. It holds the mesh cores in reset for a fixed interval, releases them, and bounds the run by a cycle budget or an all-nodes-done condition. It emits progress ticks during the run. It then freezes the cores and streams the contents of every node's coupled RAM out over a valid/ready port, replacing fixed-length, fixed-node-count bench loops with a parametrised hardware sequencer.

## Interface
Parameters:
- NODES, 16, number of mesh nodes / coupled RAMs.
- ADDR_W, 10, RAM word-address width; each RAM is 2^ADDR_W words deep.
- DATA_W, 32, RAM word width.
- CYC_W, 32, width of the cycle counter and the budget.
- HOLD_CYCLES, 12, cycles `core_rst_n` is held low after `start`; must be ≥ 1.
- PROGRESS_STEP, 10000, run cycles between progress ticks; must be ≥ 1.

Ports (NW = $clog2(NODES)):
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request; acted on only in IDLE or DONE.
- cycle_budget  in  CYC_W  maximum run cycles, sampled on accepted `start`; 0 = unlimited.
- node_done  in  NODES  per-node completion flags.
- core_rst_n  out  1  active-low reset to all mesh cores.
- running  out  1  high in RUN.
- progress_tick  out  1  one-cycle pulse every PROGRESS_STEP run cycles.
- ram_rd_en  out  1  read strobe to the RAM mux.
- ram_rd_node  out  NW  node select.
- ram_rd_addr  out  ADDR_W  word address.
- ram_rd_data  in  DATA_W  read data, valid exactly 1 cycle after `ram_rd_en`.
- dump_valid / dump_ready  out / in  1  output stream handshake.
- dump_node, dump_addr, dump_data  out  NW, ADDR_W, DATA_W  dumped word and its origin.
- dump_last  out  1  marks the final word: node NODES-1, address 2^ADDR_W-1.
- timed_out  out  1  the run ended on budget expiry.
- finished  out  1  the dump is complete.

## Operation
- States: IDLE → HOLD → RUN → DUMP → DONE.
- IDLE:
  - `core_rst_n`=0.
  - `start` latches `cycle_budget`, clears `timed_out` and `finished`, and enters HOLD.
- HOLD:
  - `core_rst_n`=0 for exactly HOLD_CYCLES cycles, then RUN.
- RUN:
  - `core_rst_n`=1 and `running`=1.
  - Cycle counter `cnt` starts at 0 and increments every cycle.
  - `progress_tick`=1 in the cycle after `cnt` reaches k·PROGRESS_STEP−1, for each k ≥ 1.
  - The run ends when `&node_done`=1 or, with a non-zero budget, when `cnt` = budget−1.
  - If both conditions occur in the same cycle, done wins and `timed_out` stays 0.
  - On budget expiry alone, `timed_out`←1.
- DUMP:
  - `core_rst_n`=0, which freezes the cores.
  - Words are read in order: node 0 addresses 0..2^ADDR_W−1, then node 1, and so on.
  - A read is issued only if buffer occupancy plus the in-flight read count is less than 2.
  - Returned data is pushed into the 2-entry output buffer together with its node and address.
  - The state leaves DUMP when the word carrying `dump_last` is accepted (`dump_valid`&&`dump_ready`).
- DONE:
  - `finished`=1, `core_rst_n`=0.
  - `start` re-enters HOLD and clears the flags.
- `start` is ignored in HOLD, RUN and DUMP.
- Counters: `cnt` is CYC_W bits and does not wrap in the unlimited case (it saturates at all-ones). The node and address walk carries from address to node, and no read is issued past the last word.

## Timing
- Reset values: `core_rst_n`=0, and `running`, `progress_tick`, `ram_rd_en`, `dump_valid`, `dump_last`, `timed_out`, `finished` all 0. `dump_node`, `dump_addr`, `dump_data` are 0. State is IDLE.
- `start` at edge t puts HOLD in effect from t+1. `core_rst_n` rises at t+1+HOLD_CYCLES.
- The end of RUN is registered: `core_rst_n` falls on the edge after the end condition is sampled.
- Dump read latency is 1 cycle. `dump_valid` rises at the earliest 2 cycles after DUMP entry.
- With `dump_ready` held at 1, the stream sustains 1 word per cycle. Total dump length is NODES·2^ADDR_W words.
- Handshake rules:
  - While `dump_valid`=1 and `dump_ready`=0, all dump outputs hold stable.
  - `dump_valid` never drops without a handshake.
- Backpressure never drops a word: an in-flight read always has a free buffer entry.
- `rst` asserted mid-operation:
  - All state returns to reset values on that edge.
  - In-flight read data and buffer contents are discarded.
  - `core_rst_n`=0.

## Structure
- Package `mesh_run_pkg` holds:
  - the state enum `run_state_t` (IDLE, HOLD, RUN, DUMP, DONE);
  - the packed struct `dump_word_t` {node, addr, data, last}, parameterised through localparams matching the instantiating defaults.
- Sub-module `dump_skid_fifo`:
  - 2-entry valid/ready FIFO of `dump_word_t`;
  - exports `count` so the controller can apply the read-credit check.
- The controller holds the FSM, the cycle and progress counters, and the read address walk.

## Test plan
- Basic run: NODES=4, ADDR_W=2, HOLD_CYCLES=12, budget=0, `node_done`=4'hF raised at run cycle 50 → `core_rst_n` high for exactly 50 cycles after 12 hold cycles, `timed_out`=0, 16 words dumped in node/addr order, `dump_last` only on (3,3), then `finished`=1.
- Budget expiry: budget=100, `node_done` never full, PROGRESS_STEP=25 → 4 ticks at run cycles 25/50/75/100, RUN lasts 100 cycles, `timed_out`=1.
- Simultaneous end: `&node_done` rises exactly at `cnt`=budget−1 → `timed_out`=0.
- Backpressure: RAM preloaded with data = {node, addr}, `dump_ready` random at 30% → every word appears once, in order, with correct data, and outputs hold stable while stalled.
- Reset mid-dump: assert `rst` after 5 dump words → all outputs return to reset values on the next edge; a new `start` produces a full dump from (0,0).
- Ignored start: pulse `start` during RUN and DUMP → no state change and no budget re-latch.
